csoc_uart_rx: RTL and testbench
===============================

Name: csoc_uart_rx

Overview:
- UART receive front end for the CSoC test harness. Converts the board `rx` serial line (8N1, LSB first) into bytes.
- Sits directly upstream of the csoc_test command/data path. Delivers each byte through a one-entry valid/ready buffer.
- Reports framing errors and overruns as one-cycle status pulses for debug LEDs.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line baud rate.
- OVERSAMPLE, 16, ticks per bit period. Fixed at 16; other values are unsupported.
- DIV, CLK_FREQ/(BAUD*OVERSAMPLE) rounded to nearest, clocks per tick. Must be ≥1.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- rx  input  1  asynchronous serial line, idle high.
- data_o  output  8  received byte.
- valid_o  output  1  data_o holds an unconsumed byte.
- ready_i  input  1  consumer accepts the byte when valid_o & ready_i.
- frame_err_o  output  1  one-cycle pulse when the stop bit is sampled low.
- overrun_o  output  1  one-cycle pulse when a byte is dropped because the buffer is full.
- busy_o  output  1  high while the FSM is outside IDLE.

Behaviour:
- Reset values: data_o=0x00, valid_o=0, frame_err_o=0, overrun_o=0, busy_o=0, FSM=IDLE. Both synchronizer flops reset to 1. Tick counter and bit counter reset to 0.
- Reset applied mid-frame aborts the frame immediately. No valid_o or error pulse is produced.
- rx passes through a 2-FF synchronizer (rx_s). All logic below uses rx_s only.
- Tick generator:
  - Counter runs 0..DIV-1 and asserts tick for one clk on wrap.
  - It is cleared to 0 on entry to START so that bit timing aligns to the detected edge.
- FSM states and transitions:
  - IDLE: rx_s==0 -> START; clear tick and sample counters.
  - START: on tick 8 take a majority vote of the samples at ticks 7, 8 and 9, with the decision made at tick 9. Result 1 (glitch) -> IDLE with no output. Result 0 -> DATA at tick 15, bit index 0.
  - DATA: each bit is decided by a majority of ticks 7/8/9 of its 16-tick period. The decided bit shifts into bit[index], LSB first. After index 7 completes its 16 ticks -> STOP.
  - STOP: majority at ticks 7/8/9.
    - Result 1 -> byte complete, go to IDLE at tick 9. Do not wait for the end of the stop bit.
    - Result 0 -> frame_err_o pulse, byte discarded, go to BREAK.
  - BREAK: remain until rx_s==1, then -> IDLE. No false start is taken from a held-low line.
- Output buffer, on byte complete (cycle C):
  - valid_o==0: data_o and valid_o=1 are updated at C+1.
  - valid_o==1 and ready_i==1 in cycle C: old byte is consumed, new byte loads at C+1, valid_o stays 1.
  - valid_o==1 and ready_i==0: new byte dropped, data_o keeps the old value, overrun_o pulses at C+1.
  - Handshake: valid_o&ready_i without a completing byte -> valid_o=0 next cycle; data_o holds its last value. data_o never changes while valid_o=1 unless a handshake occurs.
- Latency:
  - valid_o rises 1 clk after the deciding stop-bit sample, plus the 2 synchronizer clks from the line.
  - In total this is about 9.5 bit periods after the start edge.
- frame_err_o and overrun_o are never asserted together in the same cycle. Both are registered.
- busy_o = (state != IDLE), registered with the state.

Decomposition:
- Shared package csoc_uart_pkg holds:
  - the state enum (IDLE, START, DATA, STOP, BREAK);
  - constant OVERSAMPLE=16 and sample indices MID_LO=7, MID=8, MID_HI=9;
  - the DIV computation function.
  This lets the future csoc_uart_tx reuse the same baud math.
- One sub-module is natural: uart_baud_tick (parameter DIV; ports clk, rst, clr, tick).
- The synchronizer stays inline.

Test Plan:
- Setup for all tests: CLK_FREQ=1600000, BAUD=100000, so DIV=1 and one bit = 16 clks.
- Single byte: drive 0xA5 framed 8N1, ready_i=1 -> exactly one valid_o cycle with data_o=0xA5; no error pulses; busy_o low again before the stop bit ends.
- Glitch rejection: rx low for 3 clks then high -> FSM returns to IDLE; valid_o, frame_err_o and overrun_o stay 0.
- Framing error: send 0x3C with stop bit 0, then hold rx low 40 clks, then release -> one frame_err_o pulse; valid_o stays 0. A subsequent 0x5A frame is received correctly.
- Overrun: send 0x55 then 0xAA back-to-back with ready_i=0 -> valid_o=1, data_o=0x55, one overrun_o pulse after the second stop bit. Raising ready_i then drops valid_o.
- Simultaneous accept/complete: hold 0x11 pending, send 0x22, assert ready_i exactly in the completion cycle -> no overrun; valid_o stays 1 and data_o becomes 0x22.
- Reset mid-frame: assert rst during data bit 4 of 0xF0 -> all outputs zero immediately. After release, an idle line produces nothing and the next frame 0x81 is received correctly.

Source files
------------

// File: rtl/csoc_uart_pkg.sv
// Shared UART definitions: FSM states, oversampling constants, baud divider math.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package csoc_uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_e;

    localparam int OVERSAMPLE = 16;
    localparam int MID_LO     = 7;
    localparam int MID        = 8;
    localparam int MID_HI     = 9;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int calc_div(input int clk_freq, input int baud);
        return (clk_freq + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks, restartable by clr.
// Latency: tick asserts combinationally when the counter reaches DIV-1.
// Backpressure: none; free-running.
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Wrap at DIV-1; clr realigns the phase to the detected start edge.
    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = cnt_q + W'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/csoc_uart_rx.sv
// UART 8N1 receiver with 16x oversampling, majority-vote bit decisions and a 1-entry output buffer.
// Latency: valid_o rises 1 clk after the deciding stop-bit sample (+2 clk synchronizer).
// Backpressure: a byte completing while the buffer is full and not being drained is dropped (overrun_o).
module csoc_uart_rx
    import csoc_uart_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD);
    localparam logic [3:0] T_LO   = 4'(MID_LO);
    localparam logic [3:0] T_MID  = 4'(MID);
    localparam logic [3:0] T_HI   = 4'(MID_HI);
    localparam logic [3:0] T_LAST = 4'(OVERSAMPLE - 1);

    uart_state_e state_q, state_d;
    logic        rx_meta_q, rx_meta_d;
    logic        rx_s_q, rx_s_d;
    logic [3:0]  sc_q, sc_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [1:0]  samp_q, samp_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
    logic        ovr_q, ovr_d;
    logic        busy_q, busy_d;

    logic tick;
    logic tick_clr;
    logic maj;
    logic byte_done;
    logic ferr_hit;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (tick_clr),
        .tick (tick)
    );

    // Frame FSM: edge detect, per-bit majority vote at ticks 7/8/9, stop check.
    always_comb begin
        state_d   = state_q;
        sc_d      = sc_q;
        bit_idx_d = bit_idx_q;
        samp_d    = samp_q;
        shreg_d   = shreg_q;
        rx_meta_d = rx;
        rx_s_d    = rx_meta_q;
        tick_clr  = 1'b0;
        byte_done = 1'b0;
        ferr_hit  = 1'b0;
        maj       = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);

        if (tick && state_q != IDLE && state_q != BREAK) begin
            sc_d = sc_q + 4'd1;
            if (sc_q == T_LO)  samp_d[0] = rx_s_q;
            if (sc_q == T_MID) samp_d[1] = rx_s_q;
        end

        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d  = START;
                    sc_d     = 4'd0;
                    tick_clr = 1'b1;
                end
            end
            START: begin
                if (tick && sc_q == T_HI && maj) begin
                    state_d = IDLE;
                end else if (tick && sc_q == T_LAST) begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                end
            end
            DATA: begin
                if (tick && sc_q == T_HI) begin
                    shreg_d[bit_idx_q] = maj;
                end
                if (tick && sc_q == T_LAST) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                // Decide at mid-stop; do not wait for the bit to end.
                if (tick && sc_q == T_HI) begin
                    if (maj) begin
                        byte_done = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        ferr_hit = 1'b1;
                        state_d  = BREAK;
                    end
                end
            end
            BREAK: begin
                // Held-low line must return high before a new start is accepted.
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // One-entry output buffer and registered status pulses.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        ferr_d  = ferr_hit;
        busy_d  = (state_d != IDLE);
        if (byte_done) begin
            if (!valid_q || ready_i) begin
                data_d  = shreg_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            sc_q      <= 4'd0;
            bit_idx_q <= 3'd0;
            samp_q    <= 2'b11;
            shreg_q   <= 8'h00;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_meta_q <= rx_meta_d;
            rx_s_q    <= rx_s_d;
            sc_q      <= sc_d;
            bit_idx_q <= bit_idx_d;
            samp_q    <= samp_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
            busy_q    <= busy_d;
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = ferr_q;
    assign overrun_o   = ovr_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_csoc_uart_rx.sv
// Bench for csoc_uart_rx: table-driven frames, hand-written corner sequences, randomized frames.
// Latency: one bit = 16 clks (DIV=1).
// Backpressure: ready_i driven by the bench per test.
module tb_csoc_uart_rx;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;

    csoc_uart_rx #(.CLK_FREQ(1600000), .BAUD(100000)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    int n_hs   = 0;
    int n_ferr = 0;
    int n_ovr  = 0;
    int n_vlow = 0;
    logic [7:0] got [$];

    logic       prev_valid = 1'b0;
    logic       prev_hs    = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: collect handshakes/pulses and check buffer stability rules.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (valid_o && ready_i) begin
                got.push_back(data_o);
                n_hs++;
            end
            if (frame_err_o) n_ferr++;
            if (overrun_o)   n_ovr++;
            if (!valid_o)    n_vlow++;
            if (frame_err_o || overrun_o) begin
                chk("pulse_exclusive", {31'd0, frame_err_o & overrun_o}, 32'd0);
            end
            if (prev_valid && !prev_hs) begin
                chk("hold_valid", {31'd0, valid_o}, 32'd1);
                chk("hold_data", {24'd0, data_o}, {24'd0, prev_data});
            end
            prev_valid = valid_o;
            prev_hs    = valid_o & ready_i;
            prev_data  = data_o;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic clks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one 8N1 frame; optional 1-clk ready pulse in the completion cycle; busy sampled late in stop.
    task automatic send_frame(input logic [7:0] b, input logic stop, input bit pulse_rdy,
                              output logic busy_late);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        busy_late = 1'b1;
        for (int j = 0; j < 10; j++) begin
            rx = fr[j];
            for (int k = 1; k <= 16; k++) begin
                @(posedge clk);
                #1;
                if (j == 9) begin
                    if (k == 12 && pulse_rdy) ready_i = 1'b1;
                    if (k == 13 && pulse_rdy) ready_i = 1'b0;
                    if (k == 14) busy_late = busy_o;
                end
            end
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_bytes;
        int         exp_ferr;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int hs0, ferr0, ovr0, vlow0;
        logic bl;
        logic [7:0] exp_q [$];
        int exp_ferr;

        vecs[0] = '{8'hA5, 1'b1, 1, 0};
        vecs[1] = '{8'h00, 1'b1, 1, 0};
        vecs[2] = '{8'hFF, 1'b1, 1, 0};
        vecs[3] = '{8'h3C, 1'b0, 0, 1};
        vecs[4] = '{8'h5A, 1'b1, 1, 0};
        vecs[5] = '{8'h81, 1'b1, 1, 0};

        rst = 1'b1;
        rx = 1'b1;
        ready_i = 1'b0;
        clks(3);
        chk("rst_data", {24'd0, data_o}, 32'd0);
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_ferr", {31'd0, frame_err_o}, 32'd0);
        chk("rst_ovr", {31'd0, overrun_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        rst = 1'b0;
        clks(20);

        // Table-driven single frames with ready held high.
        ready_i = 1'b1;
        for (int v = 0; v < 6; v++) begin
            hs0 = n_hs; ferr0 = n_ferr; ovr0 = n_ovr;
            send_frame(vecs[v].data, vecs[v].stop, 1'b0, bl);
            if (!vecs[v].stop) begin
                clks(40);
                rx = 1'b1;
            end
            clks(20);
            chk("vec_bytes", n_hs - hs0, vecs[v].exp_bytes);
            if (vecs[v].exp_bytes == 1 && n_hs > 0)
                chk("vec_data", {24'd0, got[got.size()-1]}, {24'd0, vecs[v].data});
            chk("vec_ferr", n_ferr - ferr0, vecs[v].exp_ferr);
            chk("vec_ovr", n_ovr - ovr0, 0);
            if (vecs[v].stop) chk("vec_busy_in_stop", {31'd0, bl}, 32'd0);
            chk("vec_idle_busy", {31'd0, busy_o}, 32'd0);
            chk("vec_idle_valid", {31'd0, valid_o}, 32'd0);
        end

        // Glitch rejection: 3-clk low pulse.
        hs0 = n_hs; ferr0 = n_ferr; ovr0 = n_ovr;
        rx = 1'b0;
        clks(3);
        rx = 1'b1;
        clks(3);
        chk("glitch_busy_high", {31'd0, busy_o}, 32'd1);
        clks(40);
        chk("glitch_busy_low", {31'd0, busy_o}, 32'd0);
        chk("glitch_bytes", n_hs - hs0, 0);
        chk("glitch_ferr", n_ferr - ferr0, 0);
        chk("glitch_ovr", n_ovr - ovr0, 0);
        chk("glitch_valid", {31'd0, valid_o}, 32'd0);

        // Overrun: two back-to-back frames with no consumer.
        ready_i = 1'b0;
        hs0 = n_hs; ferr0 = n_ferr; ovr0 = n_ovr;
        send_frame(8'h55, 1'b1, 1'b0, bl);
        send_frame(8'hAA, 1'b1, 1'b0, bl);
        rx = 1'b1;
        clks(5);
        chk("ovr_valid", {31'd0, valid_o}, 32'd1);
        chk("ovr_data", {24'd0, data_o}, 32'h55);
        chk("ovr_pulses", n_ovr - ovr0, 1);
        chk("ovr_ferr", n_ferr - ferr0, 0);
        chk("ovr_no_hs", n_hs - hs0, 0);
        ready_i = 1'b1;
        clks(1);
        ready_i = 1'b0;
        chk("ovr_drain_valid", {31'd0, valid_o}, 32'd0);
        chk("ovr_drain_hs", n_hs - hs0, 1);
        if (n_hs > 0) chk("ovr_drain_data", {24'd0, got[got.size()-1]}, 32'h55);

        // Accept of the old byte in the same cycle the new byte completes.
        send_frame(8'h11, 1'b1, 1'b0, bl);
        clks(5);
        chk("sim_pending_data", {24'd0, data_o}, 32'h11);
        hs0 = n_hs; ovr0 = n_ovr; vlow0 = n_vlow;
        send_frame(8'h22, 1'b1, 1'b1, bl);
        clks(5);
        chk("sim_valid", {31'd0, valid_o}, 32'd1);
        chk("sim_data", {24'd0, data_o}, 32'h22);
        chk("sim_no_ovr", n_ovr - ovr0, 0);
        chk("sim_no_gap", n_vlow - vlow0, 0);
        chk("sim_hs", n_hs - hs0, 1);
        if (n_hs > 0) chk("sim_hs_data", {24'd0, got[got.size()-1]}, 32'h11);

        // Reset during data bit 4 of 0xF0, with a byte still pending.
        rx = 1'b0;
        clks(16);
        for (int j = 0; j < 4; j++) begin
            rx = 1'b0;
            clks(16);
        end
        rx = 1'b1;
        clks(8);
        chk("rstmid_busy_before", {31'd0, busy_o}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rstmid_data", {24'd0, data_o}, 32'd0);
        chk("rstmid_valid", {31'd0, valid_o}, 32'd0);
        chk("rstmid_busy", {31'd0, busy_o}, 32'd0);
        chk("rstmid_ferr", {31'd0, frame_err_o}, 32'd0);
        chk("rstmid_ovr", {31'd0, overrun_o}, 32'd0);
        clks(3);
        rst = 1'b0;
        hs0 = n_hs; ferr0 = n_ferr; ovr0 = n_ovr;
        clks(100);
        chk("rstmid_quiet_valid", {31'd0, valid_o}, 32'd0);
        chk("rstmid_quiet_busy", {31'd0, busy_o}, 32'd0);
        chk("rstmid_quiet_ferr", n_ferr - ferr0, 0);
        chk("rstmid_quiet_ovr", n_ovr - ovr0, 0);
        ready_i = 1'b1;
        send_frame(8'h81, 1'b1, 1'b0, bl);
        rx = 1'b1;
        clks(10);
        chk("rstmid_next_hs", n_hs - hs0, 1);
        if (n_hs > 0) chk("rstmid_next_data", {24'd0, got[got.size()-1]}, 32'h81);

        // Randomized frames against a queue-based reference model.
        hs0 = n_hs; ferr0 = n_ferr; ovr0 = n_ovr;
        exp_ferr = 0;
        for (int i = 0; i < 20; i++) begin
            logic [7:0] b;
            logic       st;
            b  = 8'($urandom);
            st = ($urandom_range(0, 5) != 0);
            send_frame(b, st, 1'b0, bl);
            if (st) begin
                exp_q.push_back(b);
            end else begin
                exp_ferr++;
                clks($urandom_range(0, 30));
            end
            rx = 1'b1;
            clks($urandom_range(3, 20));
        end
        clks(10);
        chk("rand_count", n_hs - hs0, exp_q.size());
        chk("rand_ferr", n_ferr - ferr0, exp_ferr);
        chk("rand_ovr", n_ovr - ovr0, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (hs0 + i < got.size())
                chk("rand_data", {24'd0, got[hs0 + i]}, {24'd0, exp_q[i]});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
